// File: rtl/cnn_dp_pkg.sv
// Shared definitions for the CNN datapath: bus/destination codes, MAC state
// encoding and the signed saturation helper.
package cnn_dp_pkg;

    localparam int CODE_DR  = 0;
    localparam int CODE_AC  = 1;
    localparam int CODE_TR  = 2;
    localparam int CODE_PC  = 3;
    localparam int CODE_MEM = 4;    // bus source: memory read data
    localparam int CODE_AR  = 4;    // destination: address register
    localparam int CODE_X   = 5;
    localparam int CODE_Y   = 6;
    localparam int CODE_IR  = 7;
    localparam int CODE_R0  = 8;

    localparam int SAT_MAX_W = 128;

    typedef enum logic [2:0] {
        MAC_IDLE = 3'd0,
        MAC_RD_V = 3'd1,
        MAC_RD_K = 3'd2,
        MAC_ACC  = 3'd3,
        MAC_DONE = 3'd4
    } mac_state_t;

    // Clamp a sign-extended value into the signed range of out_w bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          out_w
    );
        logic signed [SAT_MAX_W-1:0] lo;
        logic signed [SAT_MAX_W-1:0] hi;
        lo = '1;
        lo = lo <<< (out_w - 1);
        hi = ~lo;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/cnn_datapath_gen_mac_seq.sv
// MAC sequencer: fetches vector/kernel pairs over the req/ack port and
// accumulates their signed dot product. Optional ReLU via CNN_DP_RELU_EN.
module cnn_mac_seq
    import cnn_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  len,
    input  logic [ADDR_W-1:0] v_base,
    input  logic [ADDR_W-1:0] k_base,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_data
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + IDX_W;

    mac_state_t               state_reg;
    mac_state_t               state_next;
    logic [IDX_W-1:0]         cnt_reg;
    logic [ADDR_W-1:0]        vptr_reg;
    logic [ADDR_W-1:0]        kptr_reg;
    logic signed [DATA_W-1:0] v_reg;
    logic signed [DATA_W-1:0] k_reg;
    logic signed [ACC_W-1:0]  acc_reg;

    logic signed [PROD_W-1:0]    prod;
    logic signed [SAT_MAX_W-1:0] acc_ext;
    logic signed [SAT_MAX_W-1:0] sat_full;
    logic [DATA_W-1:0]           sat_data;
    logic                        unused_sat;

    assign prod = v_reg * k_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MAC_IDLE: if (start) state_next = (len == '0) ? MAC_DONE : MAC_RD_V;
            MAC_RD_V: if (mem_ack) state_next = MAC_RD_K;
            MAC_RD_K: if (mem_ack) state_next = MAC_ACC;
            MAC_ACC:  state_next = (cnt_reg == IDX_W'(1)) ? MAC_DONE : MAC_RD_V;
            MAC_DONE: state_next = MAC_IDLE;
            default:  state_next = MAC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MAC_IDLE;
            cnt_reg   <= '0;
            vptr_reg  <= '0;
            kptr_reg  <= '0;
            v_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                MAC_IDLE: begin
                    if (start) begin
                        cnt_reg  <= len;
                        vptr_reg <= v_base;
                        kptr_reg <= k_base;
                        acc_reg  <= '0;
                    end
                end
                MAC_RD_V: if (mem_ack) v_reg <= mem_rdata;
                MAC_RD_K: if (mem_ack) k_reg <= mem_rdata;
                MAC_ACC: begin
                    // Guard bits make the accumulation overflow-free for any count.
                    acc_reg  <= acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    vptr_reg <= vptr_reg + ADDR_W'(1);
                    kptr_reg <= kptr_reg + ADDR_W'(1);
                    cnt_reg  <= cnt_reg - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != MAC_IDLE);
    assign mem_req  = (state_reg == MAC_RD_V) || (state_reg == MAC_RD_K);
    assign mem_addr = (state_reg == MAC_RD_K) ? kptr_reg : vptr_reg;
    assign wb_en    = (state_reg == MAC_DONE);

    assign acc_ext    = {{(SAT_MAX_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
    assign sat_full   = sat_signed(acc_ext, DATA_W);
    assign sat_data   = sat_full[DATA_W-1:0];
    assign unused_sat = ^sat_full[SAT_MAX_W-1:DATA_W];

`ifdef CNN_DP_RELU_EN
    assign wb_data = sat_data[DATA_W-1] ? '0 : sat_data;
`else
    assign wb_data = sat_data;
`endif

endmodule

// File: rtl/cnn_datapath_gen.sv
// Parametrised CNN datapath: register file, bus mux and MAC sequencer.
// Optional ReLU on MAC writeback via CNN_DP_RELU_EN (see cnn_mac_seq).
module cnn_datapath_gen
    import cnn_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int NREG   = 8,
    parameter int IDX_W  = 8,
    localparam int SEL_W = $clog2(8 + NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  bus_sel,
    input  logic [SEL_W-1:0]  dst_sel,
    input  logic              wr_en,
    input  logic              pc_inc,
    input  logic              ar_inc,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              mac_start,
    input  logic [IDX_W-1:0]  mac_len,
    output logic              mac_busy,
    output logic              mac_done,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ac_value,
    output logic [DATA_W-1:0] ir_value,
    output logic [ADDR_W-1:0] pc_value
);

    logic [DATA_W-1:0] dr_reg;
    logic [DATA_W-1:0] ac_reg;
    logic [DATA_W-1:0] tr_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] ar_reg;
    logic [IDX_W-1:0]  x_reg;
    logic [IDX_W-1:0]  y_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] r_reg [NREG];
    logic              done_reg;

    logic [DATA_W-1:0] bus;
    logic [NREG-1:0]   r_we;
    logic              wr_dr, wr_ac, wr_tr, wr_pc, wr_ar, wr_x, wr_y, wr_ir;

    logic              seq_mem_req;
    logic [ADDR_W-1:0] seq_mem_addr;
    logic              seq_wb_en;
    logic [DATA_W-1:0] seq_wb_data;

    assign wr_dr = wr_en && (dst_sel == SEL_W'(CODE_DR));
    assign wr_ac = wr_en && (dst_sel == SEL_W'(CODE_AC));
    assign wr_tr = wr_en && (dst_sel == SEL_W'(CODE_TR));
    assign wr_pc = wr_en && (dst_sel == SEL_W'(CODE_PC));
    assign wr_ar = wr_en && (dst_sel == SEL_W'(CODE_AR));
    assign wr_x  = wr_en && (dst_sel == SEL_W'(CODE_X));
    assign wr_y  = wr_en && (dst_sel == SEL_W'(CODE_Y));
    assign wr_ir = wr_en && (dst_sel == SEL_W'(CODE_IR));

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_r_we
            assign r_we[gi] = wr_en && (dst_sel == SEL_W'(CODE_R0 + gi));
        end
    endgenerate

    always_comb begin
        bus = '0;
        case (bus_sel)
            SEL_W'(CODE_DR):  bus = dr_reg;
            SEL_W'(CODE_AC):  bus = ac_reg;
            SEL_W'(CODE_TR):  bus = tr_reg;
            SEL_W'(CODE_PC):  bus = DATA_W'(pc_reg);
            SEL_W'(CODE_MEM): bus = mem_rdata;
            SEL_W'(CODE_X):   bus = DATA_W'(x_reg);
            SEL_W'(CODE_Y):   bus = DATA_W'(y_reg);
            SEL_W'(CODE_IR):  bus = ir_reg;
            default:          bus = '0;
        endcase
        for (int i = 0; i < NREG; i++) begin
            if (bus_sel == SEL_W'(CODE_R0 + i)) bus = r_reg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_reg   <= '0;
            ac_reg   <= '0;
            tr_reg   <= '0;
            pc_reg   <= '0;
            ar_reg   <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            ir_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            if (wr_dr) dr_reg <= bus;
            // MAC writeback beats the host; the host may not touch AC mid-MAC.
            if (seq_wb_en)                ac_reg <= seq_wb_data;
            else if (wr_ac && !mac_busy)  ac_reg <= alu_result;
            if (wr_tr) tr_reg <= bus;
            if (wr_pc)       pc_reg <= bus[ADDR_W-1:0];
            else if (pc_inc) pc_reg <= pc_reg + ADDR_W'(1);
            if (wr_ar && !mac_busy) ar_reg <= bus[ADDR_W-1:0];
            else if (ar_inc)        ar_reg <= ar_reg + ADDR_W'(1);
            if (wr_x)  x_reg  <= bus[IDX_W-1:0];
            if (wr_y)  y_reg  <= bus[IDX_W-1:0];
            if (wr_ir) ir_reg <= bus;
            done_reg <= seq_wb_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_we[i]) r_reg[i] <= bus;
            end
        end
    end

    cnn_mac_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_mac_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mac_start),
        .len       (mac_len),
        .v_base    (ar_reg),
        .k_base    (r_reg[NREG-1][ADDR_W-1:0]),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (mac_busy),
        .mem_req   (seq_mem_req),
        .mem_addr  (seq_mem_addr),
        .wb_en     (seq_wb_en),
        .wb_data   (seq_wb_data)
    );

    assign mem_req   = seq_mem_req;
    assign mem_addr  = mac_busy ? seq_mem_addr : ar_reg;
    assign mem_wdata = bus;
    assign mac_done  = done_reg;
    assign alu_a     = ac_reg;
    assign alu_b     = dr_reg;
    assign ac_value  = ac_reg;
    assign ir_value  = ir_reg;
    assign pc_value  = pc_reg;

endmodule

// File: tb/tb_cnn_datapath_gen.sv
// Self-checking bench for cnn_datapath_gen: register table, PC wrap, MAC
// scoreboard with stalls, busy-time host interference and mid-MAC reset.
module tb_cnn_datapath_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  bus_sel = '0;
    logic [3:0]  dst_sel = '0;
    logic        wr_en = 1'b0;
    logic        pc_inc = 1'b0;
    logic        ar_inc = 1'b0;
    logic [15:0] alu_result = '0;
    logic [15:0] alu_a, alu_b;
    logic        mac_start = 1'b0;
    logic [7:0]  mac_len = '0;
    logic        mac_busy, mac_done, mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] host_rdata = '0;
    logic [15:0] resp_rdata = '0;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, ac_value, ir_value;
    logic [11:0] pc_value;

    assign mem_rdata = mem_ack ? resp_rdata : host_rdata;

    cnn_datapath_gen dut (
        .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .dst_sel(dst_sel),
        .wr_en(wr_en), .pc_inc(pc_inc), .ar_inc(ar_inc),
        .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
        .mac_start(mac_start), .mac_len(mac_len), .mac_busy(mac_busy),
        .mac_done(mac_done), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ac_value(ac_value), .ir_value(ir_value), .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem [4096];

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] wval;
        logic [3:0]  rsel;
        logic        use_addr;
        logic [15:0] exp;
        string       name;
    } wr_vec_t;
    wr_vec_t vecs[$];

    // Memory responder with optional random stalls; also watches address stability.
    int          stall_max = 0;
    int          stall_left = -1;
    logic        prev_wait = 1'b0;
    logic [11:0] prev_addr = '0;
    int          addr_viol = 0;

    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            stall_left = -1;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && mem_addr !== prev_addr) addr_viol++;
            if (stall_left < 0) stall_left = $urandom_range(0, stall_max);
            if (stall_left == 0) begin
                mem_ack = 1'b1;
                resp_rdata = mem[mem_addr];
                stall_left = -1;
            end else begin
                mem_ack = 1'b0;
                stall_left--;
            end
            prev_wait = !mem_ack;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] dst, input logic [15:0] wval, input logic [3:0] rsel,
                           input logic use_addr, input logic [15:0] exp, input string name);
        wr_vec_t v;
        v.dst = dst; v.wval = wval; v.rsel = rsel; v.use_addr = use_addr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the next negedge after the write edge.
    task automatic host_write(input logic [3:0] dst, input logic [15:0] val);
        bus_sel = 4'd4; host_rdata = val; alu_result = val; dst_sel = dst; wr_en = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        $display("WR dst=%0d val=0x%04h", dst, val);
    endtask

    function automatic logic [15:0] dot_model(input int vb, input int kb, input int n);
        longint acc = 0;
        logic signed [15:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = mem[(vb + i) % 4096];
            b = mem[(kb + i) % 4096];
            acc += longint'(a) * longint'(b);
        end
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef CNN_DP_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[15:0];
    endfunction

    // Called at a negedge; returns at a negedge one cycle after mac_done.
    task automatic run_mac(input logic [7:0] len, input int exp_lat, input logic [15:0] exp_ac,
                           input string tag);
        int cyc = 0;
        logic got = 1'b0;
        logic [15:0] e;
        exp_q.push_back(exp_ac);
        mac_len = len;
        mac_start = 1'b1;
        @(posedge clk);
        #1 mac_start = 1'b0;
        while (!got && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mac_done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no mac_done expected within 300 cycles", tag);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ac"}, ac_value, e);
            chk({tag, "_busy_at_done"}, mac_busy, 0);
            if (exp_lat >= 0) chk({tag, "_latency"}, cyc, exp_lat);
            $display("MAC %s len=%0d ac=0x%04h exp=0x%04h cycles=%0d", tag, len, ac_value, e, cyc);
            @(negedge clk);
            chk({tag, "_done_pulse"}, mac_done, 0);
        end
    endtask

    logic [15:0] relu_m12;
    logic [15:0] neg_sat;
    logic        saw_done;

    initial begin
`ifdef CNN_DP_RELU_EN
        relu_m12 = 16'h0000;
        neg_sat  = 16'h0000;
`else
        relu_m12 = 16'hFFF4;
        neg_sat  = 16'h8000;
`endif
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);
        mem[12'h010] = 16'd2;    mem[12'h011] = 16'hFFFD; mem[12'h012] = 16'd4;
        mem[12'h020] = 16'd5;    mem[12'h021] = 16'd6;    mem[12'h022] = 16'hFFFF;
        mem[12'h100] = 16'h7FFF; mem[12'h101] = 16'h7FFF;
        mem[12'h200] = 16'h7FFF; mem[12'h201] = 16'h7FFF;
        mem[12'h300] = 16'h8000; mem[12'h301] = 16'h8000;
        mem[12'h400] = 16'h7FFF; mem[12'h401] = 16'h7FFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ac", ac_value, 0);
        chk("rst_pc", pc_value, 0);
        chk("rst_busy", mac_busy, 0);
        chk("rst_done", mac_done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk);

        add_vec(4'd0,  16'h1234, 4'd0,  1'b0, 16'h1234, "dr");
        add_vec(4'd1,  16'hBEEF, 4'd1,  1'b0, 16'hBEEF, "ac");
        add_vec(4'd2,  16'h5A5A, 4'd2,  1'b0, 16'h5A5A, "tr");
        add_vec(4'd3,  16'hFABC, 4'd3,  1'b0, 16'h0ABC, "pc");
        add_vec(4'd4,  16'h3010, 4'd0,  1'b1, 16'h0010, "ar");
        add_vec(4'd5,  16'h01CD, 4'd5,  1'b0, 16'h00CD, "x");
        add_vec(4'd6,  16'hFF12, 4'd6,  1'b0, 16'h0012, "y");
        add_vec(4'd7,  16'h8001, 4'd7,  1'b0, 16'h8001, "ir");
        add_vec(4'd8,  16'h1111, 4'd8,  1'b0, 16'h1111, "r0");
        add_vec(4'd15, 16'h0020, 4'd15, 1'b0, 16'h0020, "r7");
        foreach (vecs[i]) begin
            host_write(vecs[i].dst, vecs[i].wval);
            if (vecs[i].use_addr) begin
                chk(vecs[i].name, mem_addr, vecs[i].exp);
            end else begin
                bus_sel = vecs[i].rsel;
                #1 chk(vecs[i].name, mem_wdata, vecs[i].exp);
            end
        end
        chk("alu_a", alu_a, 16'hBEEF);
        chk("alu_b", alu_b, 16'h1234);
        chk("ir_value", ir_value, 16'h8001);
        @(negedge clk);

        host_write(4'd3, 16'h0FFF);
        pc_inc = 1'b1;
        @(posedge clk);
        #1 pc_inc = 1'b0;
        @(negedge clk);
        chk("pc_wrap", pc_value, 12'h000);
        bus_sel = 4'd4; host_rdata = 16'h0123; dst_sel = 4'd3; wr_en = 1'b1; pc_inc = 1'b1;
        @(posedge clk);
        #1 begin wr_en = 1'b0; pc_inc = 1'b0; end
        @(negedge clk);
        chk("pc_write_wins", pc_value, 12'h123);
        host_write(4'd4, 16'h0FFF);
        ar_inc = 1'b1;
        @(posedge clk);
        #1 ar_inc = 1'b0;
        @(negedge clk);
        chk("ar_wrap", mem_addr, 12'h000);
        host_write(4'd4, 16'h0010);

        run_mac(8'd3, 10, dot_model(12'h010, 12'h020, 3), "basic");
        chk("basic_literal", ac_value, relu_m12);
        chk("basic_ar_kept", mem_addr, 12'h010);
        bus_sel = 4'd15;
        #1 chk("basic_r7_kept", mem_wdata, 16'h0020);
        @(negedge clk);

        host_write(4'd4, 16'h0100);
        host_write(4'd15, 16'h0200);
        run_mac(8'd2, 7, dot_model(12'h100, 12'h200, 2), "possat");
        chk("possat_literal", ac_value, 16'h7FFF);

        host_write(4'd4, 16'h0300);
        host_write(4'd15, 16'h0400);
        run_mac(8'd2, 7, dot_model(12'h300, 12'h400, 2), "negsat");
        chk("negsat_literal", ac_value, neg_sat);

        host_write(4'd1, 16'h1111);
        run_mac(8'd0, 1, dot_model(0, 0, 0), "len0");

        host_write(4'd4, 16'h0010);
        host_write(4'd15, 16'h0020);
        stall_max = 3;
        addr_viol = 0;
        for (int r = 0; r < 4; r++) run_mac(8'd3, -1, dot_model(12'h010, 12'h020, 3), "stall");
        chk("stall_addr_stable", addr_viol, 0);
        stall_max = 0;

        fork
            run_mac(8'd3, 10, dot_model(12'h010, 12'h020, 3), "busy");
            begin
                repeat (2) @(negedge clk);
                host_write(4'd1, 16'h5555);
                host_write(4'd4, 16'h0777);
                mac_len = 8'd1;
                mac_start = 1'b1;
                @(posedge clk);
                #1 mac_start = 1'b0;
                @(negedge clk);
                repeat (5) @(negedge clk);
                host_write(4'd1, 16'h6666);
            end
        join
        chk("busy_ar_ignored", mem_addr, 12'h010);
        repeat (3) @(negedge clk);
        chk("busy_restart_ignored", mac_busy, 0);
        chk("busy_ac_held", ac_value, dot_model(12'h010, 12'h020, 3));

        host_write(4'd1, 16'h0BAD);
        mac_len = 8'd3;
        mac_start = 1'b1;
        @(posedge clk);
        #1 mac_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_rdk_req", mem_req, 1);
        chk("abort_in_rdk_addr", mem_addr, 12'h020);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", mac_busy, 0);
        chk("abort_ac", ac_value, 0);
        chk("abort_done", mac_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mac_done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        host_write(4'd4, 16'h0010);
        host_write(4'd15, 16'h0020);
        run_mac(8'd3, 10, dot_model(12'h010, 12'h020, 3), "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_datapath_gen.md
# cnn_datapath_gen

Parametrised successor of the CNN16 datapath: generic data/address width, a configurable general register file, and a built-in multi-cycle MAC sequencer. The sequencer fetches vector/kernel word pairs over a req/ack memory port and accumulates their dot product into AC without per-element control-unit involvement. It sits between the CNN control FSM (selects, loads, MAC start) and the shared memory. The external ALU is used for non-MAC operations.

## Interface
- DATA_W, 16, data/bus width
- ADDR_W, 12, memory address width (≤ DATA_W)
- NREG, 8, general registers R[0..NREG-1] (≥1)
- IDX_W, 8, X/Y index width and mac_len width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bus_sel  in  SEL_W  bus source; SEL_W = clog2(8+NREG)
- dst_sel  in  SEL_W  write destination
- wr_en  in  1  write bus (AC: alu_result) into dst_sel
- pc_inc, ar_inc  in  1  increment PC / AR
- alu_result  in  DATA_W  result from external ALU
- alu_a, alu_b  out  DATA_W  AC, DR to external ALU
- mac_start  in  1  start dot product
- mac_len  in  IDX_W  element count
- mac_busy  out  1  sequencer active
- mac_done  out  1  one-cycle pulse, AC updated
- mem_req  out  1  MAC read request
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  memory read data
- mem_addr  out  ADDR_W  AR when idle, MAC pointer when busy
- mem_wdata  out  DATA_W  current bus value
- ac_value, ir_value  out  DATA_W  AC, IR
- pc_value  out  ADDR_W  PC

## Operation
- Bus sources: 0 DR, 1 AC, 2 TR, 3 PC zero-ext, 4 mem_rdata, 5 X zero-ext, 6 Y zero-ext, 7 IR, 8+i R[i]. Undefined codes drive 0.
- Destinations: same codes, except 1 = AC ← alu_result, 3 = PC ← bus[ADDR_W-1:0], 4 = AR ← bus[ADDR_W-1:0]. X and Y take bus[IDX_W-1:0]. Undefined codes are no-ops.
- Write beats increment on the same register. PC and AR wrap at 2^ADDR_W.
- MAC FSM states IDLE, RD_V, RD_K, ACC, DONE.
- IDLE: mac_start with mac_len≠0 latches cnt=mac_len, vptr=AR, kptr=R[NREG-1][ADDR_W-1:0], clears acc, and goes to RD_V. mac_len=0 goes straight to DONE with acc=0.
- RD_V / RD_K: mem_req=1, mem_addr=vptr / kptr, both held until mem_ack. Data is captured on the ack cycle and the FSM advances.
- ACC: acc += signed(v)·signed(k), with acc width ACC_W = 2·DATA_W+IDX_W (no overflow). vptr and kptr increment (wrap). cnt decrements; next state is DONE if cnt reaches 0, else RD_V.
- DONE: AC ← acc saturated to signed DATA_W; mac_done=1; back to IDLE. AR and R[NREG-1] are left unchanged.
- mac_busy=1 in every non-IDLE state.

## Timing
- Reset values: all registers 0, FSM IDLE, mac_busy=0, mac_done=0, mem_req=0, mem_addr=0.
- Register writes take effect one cycle after wr_en.
- MAC latency with zero-wait ack: mac_done asserts 3·N+1 cycles after the mac_start edge. Each wait cycle on mem_ack adds one cycle.
- mac_start while busy: ignored.
- Host write to AC or AR while busy: ignored. All other destinations stay writable.
- DONE has priority over any same-cycle AC write.
- Reset mid-MAC: FSM aborts to IDLE, AC is cleared, no mac_done pulse.

## Configuration
- CNN_DP_RELU_EN defined: the DONE writeback applies ReLU after saturation, so negative results are written as 0.
- CNN_DP_RELU_EN undefined: the signed saturated value is written as is.

## Structure
- Shared package cnn_dp_pkg holds:
  - bus/destination code localparams
  - MAC state enum
  - saturation function
- Sub-module cnn_mac_seq contains the FSM, pointers, counter and accumulator. It returns the saturated result and a writeback strobe to the parent.

## Test plan
- Reset, then write DR=0x1234 via bus_sel=4 / dst_sel=0 -> DR=0x1234; AC, PC, mac_busy all 0.
- PC=0xFFF with pc_inc -> PC=0x000; wr_en dst=PC plus pc_inc in the same cycle -> write value wins.
- AR=0x010, R[7]=0x020, mac_len=3, mem v={2,-3,4}, k={5,6,-1}, zero-wait -> AC=0xFFF4 (−12), mac_done at cycle 10. With CNN_DP_RELU_EN -> AC=0.
- mac_len=2, v={0x7FFF,0x7FFF}, k={0x7FFF,0x7FFF} -> AC=0x7FFF (saturated).
- Random 0–3 cycle mem_ack stalls -> same result, mem_addr stable while mem_req=1 and ack is low.
- rst_n low during RD_K -> mac_busy=0 immediately, AC=0, no mac_done; a following mac_start runs normally.
